// File: rtl/targ_rx_buffer_pkg.sv
// Shared entry layout for the target UART receive buffer.
// An entry is {eop, err, data[7:0]}.
package targ_rx_buffer_pkg;
  localparam int TARG_RX_ENTRY_W = 10;
  localparam int TARG_RX_EOP_BIT = 9;
  localparam int TARG_RX_ERR_BIT = 8;
  localparam logic [7:0] TARG_RX_ERR_SAT = 8'hFF;
endpackage

// File: rtl/targ_rx_fifo_mem.sv
// Storage for the receive buffer: data/err RAM, per-entry eop flags and pointers.
// FWFT read of the entry at the read pointer; eop can be set on any entry.
module targ_rx_fifo_mem
  import targ_rx_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         wr_en,
  input  logic [TARG_RX_ENTRY_W-2:0]   wr_entry,
  input  logic                         rd_adv,
  input  logic                         eop_set,
  input  logic [DEPTH_LOG2-1:0]        eop_idx,
  output logic [DEPTH_LOG2-1:0]        wr_ptr,
  output logic [TARG_RX_ENTRY_W-1:0]   rd_entry
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [TARG_RX_ENTRY_W-2:0] ram [DEPTH];
  logic [DEPTH-1:0]           eop_flags;
  logic [DEPTH_LOG2-1:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Set wins over the write-clear so a write and eop in one cycle tag the new entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_eop
    logic eop_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                            eop_reg <= 1'b0;
      else if (clear)                                        eop_reg <= 1'b0;
      else if (eop_set && eop_idx == DEPTH_LOG2'(gi))        eop_reg <= 1'b1;
      else if (wr_en && wr_ptr == DEPTH_LOG2'(gi))           eop_reg <= 1'b0;
    end
    assign eop_flags[gi] = eop_reg;
  end

  assign rd_entry = {eop_flags[rd_ptr], ram[rd_ptr]};
endmodule

// File: rtl/targ_rx_buffer.sv
// Receive-side byte buffer: captures receiver strobes into an FWFT FIFO with
// err/eop tagging, sticky overflow and a saturating error counter.
module targ_rx_buffer
  import targ_rx_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_data_ready,
  input  logic                  rx_data_error,
  input  logic                  rx_endofpacket,
  input  logic                  flush,
  output logic                  rd_valid,
  output logic [7:0]            rd_data,
  output logic                  rd_err,
  output logic                  rd_eop,
  input  logic                  rd_ack,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [7:0]            err_count
);
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);

  logic                        pending;
  logic [DEPTH_LOG2-1:0]       last_wr;
  logic [DEPTH_LOG2-1:0]       wr_ptr;
  logic [TARG_RX_ENTRY_W-1:0]  head;
  logic                        wr_evt, full, do_rd, wr_accept, wr_drop, eop_fire;
  logic [DEPTH_LOG2-1:0]       eop_idx;

  assign wr_evt    = rx_data_ready | rx_data_error;
  assign full      = (count == FULL_COUNT);
  assign rd_valid  = (count != '0);
  assign do_rd     = rd_ack && rd_valid && !flush;
  assign wr_accept = wr_evt && !flush && (!full || do_rd);
  assign wr_drop   = wr_evt && !flush && full && !do_rd;

  // A same-cycle write is applied first, so eop then targets the new entry.
  assign eop_fire = rx_endofpacket && !flush && (pending || wr_accept)
                    && (rd_valid || wr_accept);
  assign eop_idx  = wr_accept ? wr_ptr : last_wr;

  targ_rx_fifo_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (flush),
    .wr_en    (wr_accept),
    .wr_entry ({rx_data_error, rx_data}),
    .rd_adv   (do_rd),
    .eop_set  (eop_fire),
    .eop_idx  (eop_idx),
    .wr_ptr   (wr_ptr),
    .rd_entry (head)
  );

  assign rd_data = head[7:0];
  assign rd_err  = head[TARG_RX_ERR_BIT];
  assign rd_eop  = head[TARG_RX_EOP_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      overflow  <= 1'b0;
      err_count <= '0;
      pending   <= 1'b0;
      last_wr   <= '0;
    end else if (flush) begin
      count     <= '0;
      overflow  <= 1'b0;
      err_count <= '0;
      pending   <= 1'b0;
      last_wr   <= '0;
    end else begin
      case ({wr_accept, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_drop) overflow <= 1'b1;
      if (wr_accept) begin
        last_wr <= wr_ptr;
        pending <= 1'b1;
        if (rx_data_error && err_count != TARG_RX_ERR_SAT)
          err_count <= err_count + 1'b1;
      end
      if (rx_endofpacket) pending <= 1'b0;
    end
  end
endmodule

// File: doc/targ_rx_buffer.md
# targ_rx_buffer

Receive-side byte buffer for the target UART path. It sits directly downstream of the target async receiver and captures every received character (`rx_data_ready` / `rx_data_error` strobes) into a first-word-fall-through FIFO. Each stored byte is tagged with a framing-error bit and, after the fact, an end-of-packet bit derived from the receiver's idle-gap pulse. The read side presents bytes to the host register interface through a valid/ack handshake, together with occupancy, sticky overflow and a saturating error counter.

## Interface
- `DEPTH_LOG2`, default 6: FIFO depth is 2^DEPTH_LOG2 entries (64).
- `clk`  in  1  system clock, the same clock as the receiver.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_data`  in  8  received byte; valid only in the cycle of a strobe.
- `rx_data_ready`  in  1  one-cycle pulse: good byte (stop bit seen).
- `rx_data_error`  in  1  one-cycle pulse: byte with bad stop bit.
- `rx_endofpacket`  in  1  one-cycle pulse: line has gone idle after activity.
- `flush`  in  1  synchronous clear of FIFO, flags and counters.
- `rd_valid`  out  1  head entry available.
- `rd_data`  out  8  head byte.
- `rd_err`  out  1  head byte was received with a framing error.
- `rd_eop`  out  1  head byte is the last byte of a packet.
- `rd_ack`  in  1  consume the head entry; ignored when `rd_valid` is 0.
- `count`  out  DEPTH_LOG2+1  entries currently stored.
- `overflow`  out  1  sticky: a byte was dropped because the FIFO was full.
- `err_count`  out  8  saturating count of error bytes accepted.

## Operation
- Write event = `rx_data_ready | rx_data_error`. Stored entry = {err = `rx_data_error`, data = `rx_data`}. The entry's eop bit is cleared on write.
- Write while full without a simultaneous `rd_ack` drops the byte and sets `overflow`. A dropped byte does not change `err_count` or `last_wr`.
- Accepted error byte: `err_count` increments and saturates at 255.
- `last_wr` register holds the index of the most recent accepted write. `pending` flag is set on every accepted write and cleared on `rx_endofpacket`.
- On `rx_endofpacket` with `pending`=1, and the entry at `last_wr` still unread (count ≠ 0): set that entry's eop bit. Otherwise the pulse has no effect.
- If a write and `rx_endofpacket` occur in the same cycle, the write is applied first and eop marks the new entry. The receiver never produces this case, but it is defined anyway.
- Read is FWFT: `rd_data`, `rd_err` and `rd_eop` are driven combinationally from the entry at `rd_ptr`. `rd_ack` with `rd_valid` advances `rd_ptr`.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth. `count` is kept as an explicit register.
- Simultaneous write and ack: both are performed and `count` is unchanged. This also applies when full (no overflow) and when empty is impossible (ack ignored).
- `flush` takes priority over everything in its cycle. It zeroes pointers, `count`, `overflow`, `err_count`, `pending` and all eop bits. Any write or ack in that cycle is discarded.

## Timing
- Reset values: `rd_valid`=0, `count`=0, `overflow`=0, `err_count`=0. `rd_data`, `rd_err` and `rd_eop` read entry 0 (don't-care, since not valid). Internally `pending`=0 and `last_wr`=0.
- Write latency: strobe in cycle N gives `rd_valid`=1 and an updated `count` in cycle N+1.
- Ack latency: ack in cycle N shows the next head (or `rd_valid`=0) in cycle N+1.
- eop latency: `rx_endofpacket` in cycle N makes `rd_eop` visible at N+1 if the tagged entry is the head.
- `overflow` asserts in the cycle after the dropped write.
- Reset asserted mid-operation clears everything asynchronously. Data RAM contents are not reset.

## Structure
- The package holds `TARG_RX_ENTRY_W` = 10 (eop, err, data[7:0]) and bit-position constants for the eop and err fields.
- The storage array plus pointers form one natural sub-module, `targ_rx_fifo_mem`. It is a simple dual-index register file with an FWFT read and a per-entry eop set port.

## Test plan
- Single good byte: `rx_data_ready` with 0x41 → next cycle `rd_valid`=1, `rd_data`=0x41, `rd_err`=0, `count`=1. Ack → `rd_valid`=0, `count`=0.
- Packet tagging: write 0x10, 0x11, 0x12, then `rx_endofpacket` → read order 0x10/eop0, 0x11/eop0, 0x12/eop1. A second `rx_endofpacket` with no new byte has no effect.
- Error byte: `rx_data_error` with 0xFF → `rd_err`=1, `err_count`=1. 300 error writes interleaved with acks → `err_count`=255.
- Overflow: 65 writes with no ack → `count`=64, `overflow`=1, and the 65th byte is absent after draining. Full plus write plus ack in the same cycle → byte accepted, `overflow` unchanged.
- Wrap-around: 200 bytes streamed with ack every cycle → data order preserved and `count` never exceeds 2.
- Flush and reset: with 5 entries and `overflow` set, `flush` → `count`=0, `overflow`=0, `err_count`=0. `rst_n` low mid-stream → all outputs at reset values while low.
